clk_div_bank: RTL
=================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 3: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 25: counter and divisor width per channel.
REQ-003 Parameter DIV_DEF, default 25000000: divisor loaded into every channel at reset.
REQ-004 clkIn  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  global enable; low freezes all channels.
REQ-007 chEn  input  NCH  per-channel enable, ANDed with en.
REQ-008 sync  input  1  synchronous phase-align strobe for all channels.
REQ-009 div  input  NCH*CNT_W  packed per-channel divisor; channel i uses bits [i*CNT_W +: CNT_W].
REQ-010 clkOut  output  NCH  registered toggle output per channel; period 2*D input cycles.
REQ-011 tick  output  NCH  registered one-cycle pulse per channel; one pulse every D input cycles.

Function
REQ-012 Each channel SHALL hold a counter cnt and a shadow divisor divCur, both CNT_W bits.
REQ-013 Effective divisor D SHALL be divCur, except divCur==0 SHALL be treated as D=1.
REQ-014 Channel active = en & chEn[i]; when inactive: cnt and clkOut hold, tick<=0, divCur holds.
REQ-015 When active and cnt != D-1: cnt<=cnt+1, tick<=0, clkOut holds.
REQ-016 When active and cnt == D-1 (terminal): cnt<=0, tick<=1, clkOut<=~clkOut, divCur<=div slice.
REQ-017 The div input SHALL take effect only at a terminal edge or on sync, never mid-period; no runt pulses on clkOut.
REQ-018 If divCur is lowered below cnt+1 by any path, the next active edge SHALL be treated as terminal (cnt >= D-1 compares as terminal).
REQ-019 sync=1 SHALL, regardless of en/chEn, set cnt<=0, tick<=0, clkOut<=0 and divCur<=div slice on all channels.
REQ-020 sync and a terminal condition in the same cycle: sync wins; no tick, no toggle.
REQ-021 With D=1 and active: tick SHALL stay high continuously and clkOut SHALL toggle every cycle (clkIn/2).
REQ-022 First tick after reset release with channel active SHALL appear after exactly D rising edges; latency from terminal count to tick/clkOut is one cycle (registered).
REQ-023 Counter arithmetic SHALL be CNT_W-bit unsigned; cnt SHALL never exceed D-1 and never wrap through 2^CNT_W.
REQ-024 Channels SHALL be fully independent apart from en, sync and rst.

Reset
REQ-025 rst low SHALL asynchronously set cnt=0, tick=0, clkOut=0 and divCur=DIV_DEF on every channel.
REQ-026 Reset asserted mid-period SHALL discard the partial count; no tick is produced for it.
REQ-027 Reset deassertion is assumed synchronised externally; first active edge after release counts as cnt 0->1.

Structure
REQ-028 A shared package SHALL hold CLK_IN_HZ=50000000 and the standard divisors: DIV_1HZ=25000000 (toggle), DIV_DISP=4091, DIV_DBC=250001, plus CNT_W default.
REQ-029 One sub-module clk_div_chan (single channel: cnt, divCur, tick, clkOut) SHALL be instantiated NCH times via generate.
REQ-030 No combinational path from any input to any output.

Verification
REQ-031 NCH=3, CNT_W=8, div={4,3,1}, en=chEn=1 after reset -> tick[0] every 4 cycles, tick[1] every 3, tick[2] constant high; clkOut periods 8, 6, 2 cycles.
REQ-032 Channel 0 div=4, change div to 10 two cycles after a tick -> current period still 4; following periods 10; no clkOut glitch.
REQ-033 div=5, drop en for 7 cycles at cnt=2 -> tick/clkOut frozen (tick=0), resumes with terminal 2 active edges after en returns.
REQ-034 Three channels at different phases, pulse sync on a cycle where channel 1 is terminal -> no tick that cycle, all clkOut=0, all channels tick together D edges later when divisors equal.
REQ-035 div=0 on channel 0 -> behaves identically to div=1; div=255 with CNT_W=8 -> tick every 255 cycles, no wrap.
REQ-036 Assert rst low asynchronously mid-period (between edges) -> outputs 0 immediately; after release with div unchanged, channels resume from DIV_DEF until first terminal or sync.

Source files
------------

// File: rtl/clk_div_bank_pkg.sv
// Shared constants for the clock divider bank: input clock rate and the
// standard divisors used by the system.
package clk_div_bank_pkg;

  localparam int unsigned CLK_IN_HZ = 32'd50000000;
  localparam int unsigned CNT_W_DEF = 32'd25;
  localparam int unsigned DIV_1HZ   = 32'd25000000;
  localparam int unsigned DIV_DISP  = 32'd4091;
  localparam int unsigned DIV_DBC   = 32'd250001;

  typedef enum logic [1:0] {
    CH_HOLD = 2'd0,
    CH_COUNT = 2'd1,
    CH_TERM = 2'd2,
    CH_SYNC = 2'd3
  } chan_op_e;

endpackage

// File: rtl/clk_div_chan.sv
// Single divider channel: counter, shadow divisor, registered tick pulse and
// toggle output. The divisor is only sampled at a terminal edge or on sync.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_1HZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             sync,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r, div_cur_r, d_eff_s, cnt_nxt_s, div_nxt_s;
  logic             tick_r, clk_out_r, tick_nxt_s, clk_nxt_s;
  chan_op_e         op_s;

  // Decode this cycle's operation and the next register values
  always_comb begin
    d_eff_s    = (div_cur_r == ZERO) ? ONE : div_cur_r;
    cnt_nxt_s  = cnt_r;
    div_nxt_s  = div_cur_r;
    tick_nxt_s = 1'b0;
    clk_nxt_s  = clk_out_r;
    // ">=" keeps a lowered divisor from letting cnt run up to a wrap
    if (sync) begin
      op_s = CH_SYNC;
    end else if (!active) begin
      op_s = CH_HOLD;
    end else if (cnt_r >= d_eff_s - ONE) begin
      op_s = CH_TERM;
    end else begin
      op_s = CH_COUNT;
    end
    case (op_s)
      CH_SYNC: begin
        cnt_nxt_s = ZERO;
        div_nxt_s = div;
        clk_nxt_s = 1'b0;
      end
      CH_TERM: begin
        cnt_nxt_s  = ZERO;
        div_nxt_s  = div;
        tick_nxt_s = 1'b1;
        clk_nxt_s  = ~clk_out_r;
      end
      CH_COUNT: begin
        cnt_nxt_s = cnt_r + ONE;
      end
      CH_HOLD: begin
        cnt_nxt_s = cnt_r;
      end
      default: begin
        cnt_nxt_s = ZERO;
      end
    endcase
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= ZERO;
      div_cur_r <= DIV_RST;
      tick_r    <= 1'b0;
      clk_out_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      div_cur_r <= div_nxt_s;
      tick_r    <= tick_nxt_s;
      clk_out_r <= clk_nxt_s;
    end
  end

  assign tick    = tick_r;
  assign clk_out = clk_out_r;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers sharing one input clock, a global
// enable, a phase-align strobe and the reset.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned NCH     = 32'd3,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_DEF = DIV_1HZ
) (
  input  logic                 clkIn,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       chEn,
  input  logic                 sync,
  input  logic [NCH*CNT_W-1:0] div,
  output logic [NCH-1:0]       clkOut,
  output logic [NCH-1:0]       tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEF);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DIV_RST(DIV_RST)
    ) u_chan (
      .clk    (clkIn),
      .rst_n  (rst),
      .active (en & chEn[i]),
      .sync   (sync),
      .div    (div[i*CNT_W +: CNT_W]),
      .tick   (tick[i]),
      .clk_out(clkOut[i])
    );
  end

endmodule
